// File: rtl/gwct_apb_arbiter.sv
// Two-master APB arbiter (CPU = master 0, GWCT debug bridge = master 1), round-robin per transfer.
// Optional ACCESS watchdog enabled by defining GWCT_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module gwct_apb_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] m0_PADDR,
  input  logic        m0_PSEL,
  input  logic        m0_PENABLE,
  input  logic        m0_PWRITE,
  input  logic [31:0] m0_PWDATA,
  input  logic [3:0]  m0_PSTRB,
  input  logic [2:0]  m0_PPROT,
  output logic [31:0] m0_PRDATA,
  output logic        m0_PREADY,
  output logic        m0_PSLVERR,
  input  logic [31:0] m1_PADDR,
  input  logic        m1_PSEL,
  input  logic        m1_PENABLE,
  input  logic        m1_PWRITE,
  input  logic [31:0] m1_PWDATA,
  input  logic [3:0]  m1_PSTRB,
  input  logic [2:0]  m1_PPROT,
  output logic [31:0] m1_PRDATA,
  output logic        m1_PREADY,
  output logic        m1_PSLVERR,
  output logic [31:0] s_PADDR,
  output logic        s_PSEL,
  output logic        s_PENABLE,
  output logic        s_PWRITE,
  output logic [31:0] s_PWDATA,
  output logic [3:0]  s_PSTRB,
  output logic [2:0]  s_PPROT,
  input  logic [31:0] s_PRDATA,
  input  logic        s_PREADY,
  input  logic        s_PSLVERR,
  output logic        owner,
  output logic        busy,
  output logic        timeout_evt
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_reg;
  logic   owner_reg;
  logic   req_any;
  logic   grant;
  logic   in_access;
  logic   done_normal;
  logic   force_done;
  logic   complete;

  assign req_any     = m0_PSEL | m1_PSEL;
  // On a tie the master that did not own the last transfer wins.
  assign grant       = (m0_PSEL & m1_PSEL) ? ~owner_reg : m1_PSEL;
  assign in_access   = (state_reg == ACCESS);
  assign done_normal = in_access & s_PREADY;
  assign complete    = done_normal | force_done;

`ifdef GWCT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_reg;

  // Counter holds the number of waited ACCESS cycles before the current one.
  assign force_done = in_access & ~s_PREADY & (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == SETUP) begin
      wait_cnt_reg <= '0;
    end else if (in_access && !s_PREADY) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = &{1'b0, TIMEOUT_CYCLES[0]};
  assign force_done     = 1'b0;
`endif

  // PENABLE from the masters is not needed: the arbiter always issues its own SETUP.
  logic unused_penable;
  assign unused_penable = &{1'b0, m0_PENABLE, m1_PENABLE};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      owner_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            state_reg <= SETUP;
            owner_reg <= grant;
          end
        end
        SETUP:   state_reg <= ACCESS;
        ACCESS:  if (complete) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign owner       = owner_reg;
  assign s_PSEL      = busy;
  assign s_PENABLE   = in_access;
  assign timeout_evt = force_done;

  always_comb begin
    s_PADDR  = '0;
    s_PWRITE = 1'b0;
    s_PWDATA = '0;
    s_PSTRB  = '0;
    s_PPROT  = '0;
    if (busy) begin
      if (owner_reg) begin
        s_PADDR  = m1_PADDR;
        s_PWRITE = m1_PWRITE;
        s_PWDATA = m1_PWDATA;
        s_PSTRB  = m1_PSTRB;
        s_PPROT  = m1_PPROT;
      end else begin
        s_PADDR  = m0_PADDR;
        s_PWRITE = m0_PWRITE;
        s_PWDATA = m0_PWDATA;
        s_PSTRB  = m0_PSTRB;
        s_PPROT  = m0_PPROT;
      end
    end
  end

  assign m0_PRDATA  = s_PRDATA;
  assign m1_PRDATA  = s_PRDATA;
  assign m0_PREADY  = ~owner_reg & complete;
  assign m1_PREADY  =  owner_reg & complete;
  assign m0_PSLVERR = ~owner_reg & ((done_normal & s_PSLVERR) | force_done);
  assign m1_PSLVERR =  owner_reg & ((done_normal & s_PSLVERR) | force_done);

endmodule
